// File: rtl/srlz_pkg.sv
// Shared definitions for the serializer/deserializer pair.
package srlz_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } srlz_state_t;

    // Bits needed to count 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry output register with valid/ready handshake.
// A word arriving while the entry is full and not drained is dropped.
module sipo_out_buf
    import srlz_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!valid || ready) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: frame alignment, bit counting
// and word assembly, feeding a single-entry output register.
module deserializer_sipo
    import srlz_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srl_in,
    input  logic                  shift,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    srlz_state_t           state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] sr, sr_n;
    logic [DATA_WIDTH-1:0] sr_shift, sr_first;
    logic                  ferr_n;
    logic                  word_done;

    // First received bit must end up in the MSB (or LSB) after a full word.
    always_comb begin
        sr_shift = '0;
        sr_first = '0;
        if (MSB_FIRST) begin
            sr_shift    = {sr[DATA_WIDTH-2:0], srl_in};
            sr_first[0] = srl_in;
        end else begin
            sr_shift               = {srl_in, sr[DATA_WIDTH-1:1]};
            sr_first[DATA_WIDTH-1] = srl_in;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        ferr_n    = 1'b0;
        word_done = 1'b0;
        if (shift) begin
            if (frame_start) begin
                ferr_n  = (state == RECV);
                sr_n    = sr_first;
                cnt_n   = CW'(1);
                state_n = RECV;
            end else if (state == RECV) begin
                sr_n = sr_shift;
                if (cnt == LAST) begin
                    word_done = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sr        <= sr_n;
            frame_err <= ferr_n;
        end
    end

    assign busy = (state == RECV);

    sipo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (word_done),
        .word   (sr_shift),
        .ready  (data_ready),
        .data   (data_out),
        .valid  (data_valid),
        .overrun(overrun)
    );

endmodule

// File: tb/tb_deserializer_sipo.sv
// Randomized and directed check of deserializer_sipo (both bit orders)
// against a bit-queue reference model.
module tb_deserializer_sipo;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srl_in = 1'b0;
    logic shift = 1'b0;
    logic frame_start = 1'b0;
    logic data_ready = 1'b0;

    logic [W-1:0] dout_m, dout_l;
    logic valid_m, valid_l, busy_m, busy_l;
    logic ovr_m, ovr_l, ferr_m, ferr_l;

    always #5 clk = ~clk;

    deserializer_sipo #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .srl_in(srl_in), .shift(shift),
        .frame_start(frame_start), .data_out(dout_m),
        .data_valid(valid_m), .data_ready(data_ready), .busy(busy_m),
        .overrun(ovr_m), .frame_err(ferr_m)
    );

    deserializer_sipo #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .srl_in(srl_in), .shift(shift),
        .frame_start(frame_start), .data_out(dout_l),
        .data_valid(valid_l), .data_ready(data_ready), .busy(busy_l),
        .overrun(ovr_l), .frame_err(ferr_l)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of received bits.
    bit           q[$];
    bit           in_frame = 0;
    logic [W-1:0] m_dm = '0, m_dl = '0;
    bit           m_v = 0, m_o = 0, m_f = 0;

    logic [W-1:0] e_dm = '0, e_dl = '0;
    bit           e_v = 0, e_o = 0, e_f = 0, e_b = 0;
    bit           chk_en = 0;

    task automatic model_step();
        bit           done;
        logic [W-1:0] wm, wl;
        done = 0;
        wm = '0;
        wl = '0;
        if (rst) begin
            q.delete();
            in_frame = 0;
            m_dm = '0;
            m_dl = '0;
            m_v = 0;
            m_o = 0;
            m_f = 0;
        end else begin
            m_o = 0;
            m_f = 0;
            if (shift) begin
                if (frame_start) begin
                    m_f = in_frame;
                    q.delete();
                    q.push_back(srl_in);
                    in_frame = 1;
                end else if (in_frame) begin
                    q.push_back(srl_in);
                    if (q.size() == W) begin
                        done = 1;
                        for (int i = 0; i < W; i++) begin
                            wm = {wm[W-2:0], q[i]};
                            wl[i] = q[i];
                        end
                        q.delete();
                        in_frame = 0;
                    end
                end
            end
            if (done) begin
                if (!m_v || data_ready) begin
                    m_dm = wm;
                    m_dl = wl;
                    m_v = 1;
                end else begin
                    m_o = 1;
                end
            end else if (m_v && data_ready) begin
                m_v = 0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic f,
                        input logic d, input logic rd);
        rst = r;
        shift = s;
        frame_start = f;
        srl_in = d;
        data_ready = rd;
        model_step();
        @(posedge clk);
        e_dm = m_dm;
        e_dl = m_dl;
        e_v = m_v;
        e_o = m_o;
        e_f = m_f;
        e_b = in_frame;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_m", 32'(valid_m), 32'(e_v));
            chk("valid_l", 32'(valid_l), 32'(e_v));
            chk("data_m", 32'(dout_m), 32'(e_dm));
            chk("data_l", 32'(dout_l), 32'(e_dl));
            chk("busy_m", 32'(busy_m), 32'(e_b));
            chk("busy_l", 32'(busy_l), 32'(e_b));
            chk("ovr_m", 32'(ovr_m), 32'(e_o));
            chk("ovr_l", 32'(ovr_l), 32'(e_o));
            chk("ferr_m", 32'(ferr_m), 32'(e_f));
            chk("ferr_l", 32'(ferr_l), 32'(e_f));
        end
    end

    // Sends v MSB first; gap idle cycles (with stray frame_start) per bit.
    task automatic send(input logic [W-1:0] v, input int gap,
                        input logic rdy_body, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            for (int g = 0; g < gap; g++)
                tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), rdy_body);
            tick(1'b0, 1'b1, (i == 0), v[W-1-i],
                 (i == W - 1) ? rdy_last : rdy_body);
        end
    endtask

    logic [W-1:0] c3;

    initial begin
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_en = 1;
        chk("rst_valid", 32'(valid_m), 32'h0);
        chk("rst_data", 32'(dout_m), 32'h0);
        chk("rst_busy", 32'(busy_l), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Clean words
        send(8'hA5, 0, 1'b1, 1'b1);
        chk("a5_m", 32'(dout_m), 32'hA5);
        chk("a5_l", 32'(dout_l), 32'hA5);
        chk("a5_valid", 32'(valid_m), 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_drop", 32'(valid_m), 32'h0);
        send(8'h3C, 0, 1'b1, 1'b1);
        chk("3c_m", 32'(dout_m), 32'h3C);
        chk("3c_l", 32'(dout_l), 32'h3C);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped strobes
        send(8'h5A, 2, 1'b1, 1'b1);
        chk("5a_m", 32'(dout_m), 32'h5A);
        chk("5a_l", 32'(dout_l), 32'h5A);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-word resync
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        c3 = 8'hC3;
        tick(1'b0, 1'b1, 1'b1, c3[7], 1'b1);
        chk("resync_ferr", 32'(ferr_m), 32'h1);
        for (int i = 1; i < W; i++) begin
            tick(1'b0, 1'b1, 1'b0, c3[W-1-i], 1'b1);
            if (i == 1) chk("resync_ferr_once", 32'(ferr_m), 32'h0);
        end
        chk("c3_m", 32'(dout_m), 32'hC3);
        chk("c3_valid", 32'(valid_m), 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun
        send(8'h11, 0, 1'b0, 1'b0);
        send(8'h22, 0, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(ovr_m), 32'h1);
        chk("ovr_hold", 32'(dout_m), 32'h11);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_once", 32'(ovr_m), 32'h0);
        chk("ovr_drain", 32'(valid_m), 32'h0);

        // Handshake coinciding with completion
        send(8'h33, 0, 1'b0, 1'b0);
        send(8'h44, 0, 1'b0, 1'b1);
        chk("sim_valid", 32'(valid_m), 32'h1);
        chk("sim_data", 32'(dout_m), 32'h44);
        chk("sim_ovr", 32'(ovr_m), 32'h0);

        // Reset mid-operation with a word pending
        for (int i = 0; i < 5; i++)
            tick(1'b0, 1'b1, (i == 0), 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst_valid", 32'(valid_m), 32'h0);
        chk("mrst_data", 32'(dout_m), 32'h0);
        chk("mrst_busy", 32'(busy_m), 32'h0);
        for (int i = 0; i < 12; i++)
            tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mrst_ignore_busy", 32'(busy_m), 32'h0);
        chk("mrst_ignore_valid", 32'(valid_m), 32'h0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6));
        end

        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
